// File: rtl/instr_decode_rv_pkg.sv
// -----------------------------------------------------------------------------
// instr_decode_rv_pkg
// Shared RV32I decode constants: base opcodes, plus the funct3/funct7 codes
// that the exec stage uses to pick the ALU, branch and load/store operation.
// isLegalOpcode() tells whether an opcode belongs to the supported base set.
// -----------------------------------------------------------------------------
package instr_decode_rv_pkg;

   // Base opcodes (instr[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // funct3 for OP / OP_IMM
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   // funct3 for BRANCH
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // funct3 for LOAD / STORE (width and signedness)
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // funct7: ALT selects SUB and SRA/SRAI
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   function automatic logic isLegalOpcode(input logic [6:0] opCode);
      logic legal;
      legal = 1'b0;
      case (opCode)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
         OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: legal = 1'b1;
         default:                                  legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/sign_extend_12_32.sv
// -----------------------------------------------------------------------------
// sign_extend_12_32
// Combinational sign extension of a 12-bit immediate to 32 bits: bit 11 is
// replicated into [31:12], bits [11:0] pass through. Usable standalone.
// Ports:
//   iwValue [11:0]  12-bit field
//   owValue [31:0]  sign-extended result
// -----------------------------------------------------------------------------
module sign_extend_12_32 (
   input  logic [11:0] iwValue,
   output logic [31:0] owValue
);

   assign owValue = {{20{iwValue[11]}}, iwValue};

endmodule

// File: rtl/instr_decode_rv.sv
// -----------------------------------------------------------------------------
// instr_decode_rv
// One-cycle registered RV32I field decoder. Every field is sliced out for
// every opcode; orIllegal flags opcodes outside the supported base set
// (funct3/funct7 legality is left to the exec stage).
//
// Ports:
//   iwClk, iwRst           clock, synchronous active-high reset (clears all)
//   iwValid                iwInstr carries an instruction this cycle
//   iwStall                freeze every output, orValid included
//   iwInstr [31:0]         instruction word
//   orValid                registered fields belong to an accepted instruction
//   orRs1/orRs2/orRd       register indices
//   orOpCode/orFunct3/orFunct7
//   orImmediate20          U-type field instr[31:12]
//   orImmediate12          I-type field, plus orImmediate12Extended
//   orImmediate12SClass    S-type field, plus orImmediate12SClassExtended
//   orIllegal              opcode not in the supported base set
//
// Optional build macro INSTR_DECODE_RV_BJ_IMM_EN adds orImmB / orImmJ, the
// sign-extended branch and jump offsets.
// -----------------------------------------------------------------------------
module instr_decode_rv
   import instr_decode_rv_pkg::*;
(
   input  logic        iwClk,
   input  logic        iwRst,
   input  logic        iwValid,
   input  logic        iwStall,
   input  logic [31:0] iwInstr,
   output logic        orValid,
   output logic [4:0]  orRs1,
   output logic [4:0]  orRs2,
   output logic [4:0]  orRd,
   output logic [6:0]  orOpCode,
   output logic [2:0]  orFunct3,
   output logic [6:0]  orFunct7,
   output logic [19:0] orImmediate20,
   output logic [11:0] orImmediate12,
   output logic [11:0] orImmediate12SClass,
   output logic [31:0] orImmediate12Extended,
   output logic [31:0] orImmediate12SClassExtended,
`ifdef INSTR_DECODE_RV_BJ_IMM_EN
   output logic [31:0] orImmB,
   output logic [31:0] orImmJ,
`endif
   output logic        orIllegal
);

   logic [11:0] immI;
   logic [11:0] immS;
   logic [31:0] immIExt;
   logic [31:0] immSExt;

   assign immI = iwInstr[31:20];
   assign immS = {iwInstr[31:25], iwInstr[11:7]};

   sign_extend_12_32 uSextI (.iwValue(immI), .owValue(immIExt));
   sign_extend_12_32 uSextS (.iwValue(immS), .owValue(immSExt));

`ifdef INSTR_DECODE_RV_BJ_IMM_EN
   // Branch/jump offsets are scrambled in the encoding and always even.
   logic [31:0] immBNext;
   logic [31:0] immJNext;

   assign immBNext = {{19{iwInstr[31]}}, iwInstr[31], iwInstr[7],
                      iwInstr[30:25], iwInstr[11:8], 1'b0};
   assign immJNext = {{11{iwInstr[31]}}, iwInstr[31], iwInstr[19:12],
                      iwInstr[20], iwInstr[30:21], 1'b0};
`endif

   // Stage boundary: instruction word -> registered decode fields
   always_ff @(posedge iwClk) begin
      if (iwRst) begin
         orValid                     <= 1'b0;
         orRs1                       <= '0;
         orRs2                       <= '0;
         orRd                        <= '0;
         orOpCode                    <= '0;
         orFunct3                    <= '0;
         orFunct7                    <= '0;
         orImmediate20               <= '0;
         orImmediate12               <= '0;
         orImmediate12SClass         <= '0;
         orImmediate12Extended       <= '0;
         orImmediate12SClassExtended <= '0;
         orIllegal                   <= 1'b0;
`ifdef INSTR_DECODE_RV_BJ_IMM_EN
         orImmB                      <= '0;
         orImmJ                      <= '0;
`endif
      end else if (!iwStall) begin
         // Fields keep their last value on bubbles; only orValid drops.
         orValid <= iwValid;
         if (iwValid) begin
            orRs1                       <= iwInstr[19:15];
            orRs2                       <= iwInstr[24:20];
            orRd                        <= iwInstr[11:7];
            orOpCode                    <= iwInstr[6:0];
            orFunct3                    <= iwInstr[14:12];
            orFunct7                    <= iwInstr[31:25];
            orImmediate20               <= iwInstr[31:12];
            orImmediate12               <= immI;
            orImmediate12SClass         <= immS;
            orImmediate12Extended       <= immIExt;
            orImmediate12SClassExtended <= immSExt;
            orIllegal                   <= ~isLegalOpcode(iwInstr[6:0]);
`ifdef INSTR_DECODE_RV_BJ_IMM_EN
            orImmB                      <= immBNext;
            orImmJ                      <= immJNext;
`endif
         end
      end
   end

endmodule

// File: tb/tb_instr_decode_rv.sv
module tb_instr_decode_rv;

   logic        iwClk = 1'b0;
   logic        iwRst;
   logic        iwValid;
   logic        iwStall;
   logic [31:0] iwInstr;
   logic        orValid;
   logic [4:0]  orRs1, orRs2, orRd;
   logic [6:0]  orOpCode;
   logic [2:0]  orFunct3;
   logic [6:0]  orFunct7;
   logic [19:0] orImmediate20;
   logic [11:0] orImmediate12, orImmediate12SClass;
   logic [31:0] orImmediate12Extended, orImmediate12SClassExtended;
   logic        orIllegal;
`ifdef INSTR_DECODE_RV_BJ_IMM_EN
   logic [31:0] orImmB, orImmJ;
`endif

   int testCnt = 0;
   int failCnt = 0;

   always #5 iwClk = ~iwClk;

   instr_decode_rv dut (
      .iwClk(iwClk), .iwRst(iwRst), .iwValid(iwValid), .iwStall(iwStall),
      .iwInstr(iwInstr), .orValid(orValid), .orRs1(orRs1), .orRs2(orRs2),
      .orRd(orRd), .orOpCode(orOpCode), .orFunct3(orFunct3),
      .orFunct7(orFunct7), .orImmediate20(orImmediate20),
      .orImmediate12(orImmediate12), .orImmediate12SClass(orImmediate12SClass),
      .orImmediate12Extended(orImmediate12Extended),
      .orImmediate12SClassExtended(orImmediate12SClassExtended),
`ifdef INSTR_DECODE_RV_BJ_IMM_EN
      .orImmB(orImmB), .orImmJ(orImmJ),
`endif
      .orIllegal(orIllegal)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      testCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample 1 time unit after the edge.
   task automatic step(input logic rst, input logic vld, input logic stall,
                       input logic [31:0] instr);
      iwRst   = rst;
      iwValid = vld;
      iwStall = stall;
      iwInstr = instr;
      @(posedge iwClk);
      #1;
   endtask

   initial begin
      iwRst = 1'b1; iwValid = 1'b0; iwStall = 1'b0; iwInstr = '0;

      // Reset wins over valid instruction in the same cycle
      step(1'b1, 1'b1, 1'b0, 32'hFFF10093);
      step(1'b1, 1'b1, 1'b0, 32'hFFF10093);
      check("rst_valid",   orValid, 0);
      check("rst_opcode",  orOpCode, 0);
      check("rst_rd",      orRd, 0);
      check("rst_imm12x",  orImmediate12Extended, 0);
      check("rst_illegal", orIllegal, 0);

      // addi x1,x2,-1
      step(1'b0, 1'b1, 1'b0, 32'hFFF10093);
      check("addi_valid",  orValid, 1);
      check("addi_opcode", orOpCode, 32'h13);
      check("addi_rd",     orRd, 1);
      check("addi_rs1",    orRs1, 2);
      check("addi_f3",     orFunct3, 0);
      check("addi_imm12",  orImmediate12, 32'hFFF);
      check("addi_imm12x", orImmediate12Extended, 32'hFFFFFFFF);
      check("addi_ill",    orIllegal, 0);

      // lui x5,0x12345
      step(1'b0, 1'b1, 1'b0, 32'h123452B7);
      check("lui_opcode", orOpCode, 32'h37);
      check("lui_rd",     orRd, 5);
      check("lui_imm20",  orImmediate20, 32'h12345);
      check("lui_ill",    orIllegal, 0);

      // sw x3,8(x4)
      step(1'b0, 1'b1, 1'b0, 32'h00322423);
      check("sw_opcode", orOpCode, 32'h23);
      check("sw_rs1",    orRs1, 4);
      check("sw_rs2",    orRs2, 3);
      check("sw_f3",     orFunct3, 2);
      check("sw_immS",   orImmediate12SClass, 32'h008);
      check("sw_immSx",  orImmediate12SClassExtended, 32'h00000008);

      // sub x1,x2,x3 ; I-field 0x403 is positive
      step(1'b0, 1'b1, 1'b0, 32'h403100B3);
      check("sub_f7",     orFunct7, 32'h20);
      check("sub_rs2",    orRs2, 3);
      check("sub_rs1",    orRs1, 2);
      check("sub_rd",     orRd, 1);
      check("sub_f3",     orFunct3, 0);
      check("sub_imm12x", orImmediate12Extended, 32'h00000403);

      // Sign-extension boundaries
      step(1'b0, 1'b1, 1'b0, 32'h80000513);
      check("imm_m2048", orImmediate12Extended, 32'hFFFFF800);
      step(1'b0, 1'b1, 1'b0, 32'h7FF00513);
      check("imm_p2047", orImmediate12Extended, 32'h000007FF);
      step(1'b0, 1'b1, 1'b0, 32'hFE000FA3);
      check("immS_m1",   orImmediate12SClass, 32'hFFF);
      check("immS_m1x",  orImmediate12SClassExtended, 32'hFFFFFFFF);

      // Opcode legality
      step(1'b0, 1'b1, 1'b0, 32'h00000000);
      check("zero_ill",   orIllegal, 1);
      check("zero_valid", orValid, 1);
      step(1'b0, 1'b1, 1'b0, 32'h0000000B);
      check("custom0_ill", orIllegal, 1);
      step(1'b0, 1'b1, 1'b0, 32'h0000007F);
      check("opc7f_ill", orIllegal, 1);

      // Bubble: valid drops, fields hold
      step(1'b0, 1'b0, 1'b0, 32'h123452B7);
      check("bub_valid",  orValid, 0);
      check("bub_opcode", orOpCode, 32'h7F);
      check("bub_ill",    orIllegal, 1);

      // jal x0,-4 (legal)
      step(1'b0, 1'b1, 1'b0, 32'hFFDFF06F);
      check("jal_opcode", orOpCode, 32'h6F);
      check("jal_ill",    orIllegal, 0);
`ifdef INSTR_DECODE_RV_BJ_IMM_EN
      check("jal_immJ",   orImmJ, 32'hFFFFFFFC);
      step(1'b0, 1'b1, 1'b0, 32'hFE000EE3);
      check("beq_immB",   orImmB, 32'hFFFFFFFC);
      check("beq_ill",    orIllegal, 0);
`endif

      // Stall with a new valid instruction: everything holds
      step(1'b0, 1'b1, 1'b0, 32'h123452B7);
      step(1'b0, 1'b1, 1'b1, 32'hFFF10093);
      check("stl_valid",  orValid, 1);
      check("stl_opcode", orOpCode, 32'h37);
      check("stl_rd",     orRd, 5);
      check("stl_imm20",  orImmediate20, 32'h12345);
      // Stall with valid low must not drop orValid
      step(1'b0, 1'b0, 1'b1, 32'h00000000);
      check("stl_bub_valid", orValid, 1);
      check("stl_bub_ill",   orIllegal, 0);

      // Mid-stream reset beats stall and valid
      step(1'b0, 1'b1, 1'b0, 32'h00000000);
      check("pre_rst_ill", orIllegal, 1);
      step(1'b1, 1'b1, 1'b1, 32'hFFF10093);
      check("mrst_valid",  orValid, 0);
      check("mrst_ill",    orIllegal, 0);
      check("mrst_imm20",  orImmediate20, 0);
      check("mrst_immSx",  orImmediate12SClassExtended, 0);
      check("mrst_f7",     orFunct7, 0);

      // Recovery after reset
      step(1'b0, 1'b1, 1'b0, 32'h403100B3);
      check("rec_valid",  orValid, 1);
      check("rec_opcode", orOpCode, 32'h33);

      $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
      $finish;
   end

endmodule

// File: doc/instr_decode_rv.md
INSTR_DECODE_RV -- requirements
Module: instr_decode_rv

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port iwClk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 Port iwRst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port iwValid, input, 1 bit: iwInstr is valid this cycle.
REQ-005 Port iwStall, input, 1 bit: hold all outputs.
REQ-006 Port iwInstr, input, 32 bits: RV32I instruction word.
REQ-007 Port orValid, output, 1 bit: registered fields are valid.
REQ-008 Ports orRs1, orRs2, orRd, output, 5 bits each: instr[19:15], instr[24:20], instr[11:7].
REQ-009 Port orOpCode, output, 7 bits: instr[6:0].
REQ-010 Port orFunct3, output, 3 bits: instr[14:12].
REQ-011 Port orFunct7, output, 7 bits: instr[31:25].
REQ-012 Port orImmediate20, output, 20 bits: instr[31:12].
REQ-013 Port orImmediate12, output, 12 bits: I-type field instr[31:20].
REQ-014 Port orImmediate12SClass, output, 12 bits: S-type field {instr[31:25], instr[11:7]}.
REQ-015 Ports orImmediate12Extended and orImmediate12SClassExtended, output, 32 bits each: sign-extended forms of the two 12-bit fields.
REQ-016 Port orIllegal, output, 1 bit: the opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM or OP.

Function
REQ-017 When iwValid=1 and iwStall=0, all field outputs and orIllegal SHALL be registered from iwInstr at the rising edge, giving a latency of 1 cycle, and orValid SHALL be set to 1.
REQ-018 When iwValid=0 and iwStall=0, orValid SHALL go to 0 and the field outputs SHALL hold their previous values.
REQ-019 When iwStall=1, all outputs, including orValid, SHALL hold.
REQ-020 Sign extension SHALL replicate bit 11 into bits [31:12]; bits [11:0] SHALL pass through unchanged.
REQ-021 Opcode values SHALL be as follows: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011.
REQ-022 orIllegal SHALL depend on the opcode only; funct3/funct7 legality is checked downstream.
REQ-023 Fields SHALL be extracted for every opcode regardless of format; unused fields are don't-care to consumers but remain defined.

Reset
REQ-024 When iwRst=1 at a clock edge, every output, including orValid and orIllegal, SHALL become 0.
REQ-025 Reset SHALL take priority over iwStall and iwValid asserted in the same cycle.
REQ-026 Reset asserted mid-stream SHALL discard the pending instruction.

Configuration
REQ-027 When macro INSTR_DECODE_RV_BJ_IMM_EN is defined, the block SHALL add two 32-bit outputs:
- orImmB = sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- orImmJ = sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 0}
These outputs SHALL be registered, stalled and reset like the other fields.
REQ-028 When INSTR_DECODE_RV_BJ_IMM_EN is not defined, orImmB and orImmJ and their logic SHALL be absent.

Structure
REQ-029 Shared package instr_decode_rv_pkg SHALL hold the opcode constants and the funct3/funct7 constants used by the exec stage.
REQ-030 The block SHALL instantiate sub-module sign_extend_12_32 (12-bit in, 32-bit out, combinational) once per 12-bit field.
REQ-031 sign_extend_12_32 SHALL also be usable standalone.

Verification
REQ-032 addi x1,x2,-1: iwInstr=0xFFF10093 with iwValid=1 -> next cycle orOpCode=0x13, orRd=1, orRs1=2, orFunct3=0, orImmediate12=0xFFF, orImmediate12Extended=0xFFFFFFFF, orIllegal=0, orValid=1.
REQ-033 lui: iwInstr=0x123452B7 -> orRd=5, orImmediate20=0x12345, orIllegal=0.
REQ-034 sw: iwInstr=0x00322423 -> orRs1=4, orRs2=3, orFunct3=2, orImmediate12SClass=0x008, orImmediate12SClassExtended=0x00000008.
REQ-035 sub: iwInstr=0x403100B3 -> orFunct7=0x20, orRs2=3, orRs1=2, orRd=1.
REQ-036 Illegal, stall and reset:
- iwInstr=0x00000000 -> orIllegal=1.
- iwStall=1 with a new instruction -> outputs unchanged.
- iwRst=1 together with iwValid=1 -> all outputs 0 next cycle.
REQ-037 With INSTR_DECODE_RV_BJ_IMM_EN defined, iwInstr=0xFFDFF06F (jal x0,-4) -> orImmJ=0xFFFFFFFC.
